serial_receiver: RTL and testbench

- MSB-first deserializer that pairs with the serial transmitter.
- Accepts WIDTH-bit beats qualified by DinValid and assembles them into a DATA_W-bit word.
- Presents the word on DataOut with a valid/ack handshake toward the consumer.
- Sits on the receive side of the serial link, in the same clock domain as the sampling logic.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_rx_shifter.sv | 47 ++++
 rtl/serial_receiver.sv | 113 +++++++++++
 tb/tb_serial_receiver.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: word width, receiver states, beat math.
// The link is MSB first; the transmitter uses the same convention.
package serial_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } rx_state_t;

  function automatic int beats(input int data_w, input int width);
    return data_w / width;
  endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// MSB-first shift register with a non-wrapping beat counter.
// word is the value including the current beat; full flags the last beat.
module serial_rx_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  output logic [DATA_W-1:0] word,
  output logic              full
);

  localparam int BEATS = beats(DATA_W, WIDTH);
  localparam int CW    = $clog2(BEATS) + 1;

  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;

  generate
    if (BEATS == 1) begin : g_one
      assign word = din;
    end else begin : g_many
      assign word = {sh[DATA_W-WIDTH-1:0], din};
    end
  endgenerate

  assign full = en && (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (en) begin
      sh  <= word;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// MSB-first deserializer with valid/ack output handshake.
// Optional RX_TIMEOUT_EN aborts a stalled word and raises TimedOut.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              StartRx,
  input  logic [WIDTH-1:0]  Din,
  input  logic              DinValid,
  input  logic              DataAck,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  output logic              RxBusy,
`ifdef RX_TIMEOUT_EN
  output logic              TimedOut,
`endif
  output logic              Overrun
);

  generate
    if (DATA_W % WIDTH != 0) begin : g_bad_width
      $error("serial_receiver: DATA_W must be a multiple of WIDTH");
    end
  endgenerate

  rx_state_t state, state_nxt;
  logic              clr;
  logic              shift_en;
  logic              full;
  logic              tmo;
  logic [DATA_W-1:0] word;

  assign shift_en  = (state == RECV) && DinValid;
  assign RxBusy    = (state == RECV);
  assign DataValid = (state == DONE);

  serial_rx_shifter #(
    .WIDTH (WIDTH),
    .DATA_W(DATA_W)
  ) u_shift (
    .clk  (Clk),
    .rst_n(Reset),
    .clr  (clr),
    .en   (shift_en),
    .din  (Din),
    .word (word),
    .full (full)
  );

`ifdef RX_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall;

  assign tmo = (state == RECV) && !DinValid &&
               (stall == SW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall    <= '0;
      TimedOut <= 1'b0;
    end else begin
      if (state != RECV || DinValid) stall <= '0;
      else                           stall <= stall + 1'b1;
      if (state == IDLE && StartRx)  TimedOut <= 1'b0;
      else if (tmo)                  TimedOut <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (StartRx) begin
          state_nxt = RECV;
          clr       = 1'b1;
        end
      end
      RECV: begin
        if (full)     state_nxt = DONE;
        else if (tmo) state_nxt = IDLE;
      end
      DONE: begin
        if (DataAck) begin
          state_nxt = StartRx ? RECV : IDLE;
          clr       = StartRx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      DataOut <= '0;
      Overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (full) DataOut <= word;
      if (state == DONE && DinValid) Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed plus randomized bench for serial_receiver at WIDTH 1, 8 and 32.
// Expected words come from the transmitted values; beats are sliced arithmetically.
module tb_serial_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s1_start, s1_dv, s1_ack;
  logic [0:0]  s1_din;
  logic [31:0] s1_q;
  logic        s1_v, s1_busy, s1_ovr;
`ifdef RX_TIMEOUT_EN
  logic        s1_to;
`endif

  logic        s8_start, s8_dv, s8_ack;
  logic [7:0]  s8_din;
  logic [31:0] s8_q;
  logic        s8_v, s8_busy, s8_ovr;
`ifdef RX_TIMEOUT_EN
  logic        s8_to;
`endif

  logic        s32_start, s32_dv, s32_ack;
  logic [31:0] s32_din;
  logic [31:0] s32_q;
  logic        s32_v, s32_busy, s32_ovr;
`ifdef RX_TIMEOUT_EN
  logic        s32_to;
`endif

  serial_receiver #(.WIDTH(1), .DATA_W(32)) dut1 (
    .Clk(clk), .Reset(rst), .StartRx(s1_start), .Din(s1_din),
    .DinValid(s1_dv), .DataAck(s1_ack), .DataOut(s1_q),
    .DataValid(s1_v), .RxBusy(s1_busy),
`ifdef RX_TIMEOUT_EN
    .TimedOut(s1_to),
`endif
    .Overrun(s1_ovr)
  );

  serial_receiver #(.WIDTH(8), .DATA_W(32)) dut8 (
    .Clk(clk), .Reset(rst), .StartRx(s8_start), .Din(s8_din),
    .DinValid(s8_dv), .DataAck(s8_ack), .DataOut(s8_q),
    .DataValid(s8_v), .RxBusy(s8_busy),
`ifdef RX_TIMEOUT_EN
    .TimedOut(s8_to),
`endif
    .Overrun(s8_ovr)
  );

  serial_receiver #(.WIDTH(32), .DATA_W(32)) dut32 (
    .Clk(clk), .Reset(rst), .StartRx(s32_start), .Din(s32_din),
    .DinValid(s32_dv), .DataAck(s32_ack), .DataOut(s32_q),
    .DataValid(s32_v), .RxBusy(s32_busy),
`ifdef RX_TIMEOUT_EN
    .TimedOut(s32_to),
`endif
    .Overrun(s32_ovr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start1();
    s1_start = 1'b1;
    s1_dv    = 1'b1;
    s1_din   = 1'($urandom);
    tick();
    s1_start = 1'b0;
    s1_dv    = 1'b0;
  endtask

  // Send the top n bits of w, MSB first, with random gaps.
  task automatic beats1(input logic [31:0] w, input int n,
                        input int maxgap, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      if (chk_lat && i == 31) chk("w1_valid_before_last", s1_v, 0);
      s1_din = 1'((w >> (31 - i)) & 32'h1);
      s1_dv  = 1'b1;
      tick();
      s1_dv  = 1'b0;
    end
  endtask

  task automatic start8();
    s8_start = 1'b1;
    s8_dv    = 1'($urandom);
    s8_din   = 8'($urandom);
    tick();
    s8_start = 1'b0;
    s8_dv    = 1'b0;
  endtask

  task automatic beats8(input logic [31:0] w, input int maxgap,
                        input bit ack_junk);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      s8_din = 8'((w >> (24 - 8 * i)) & 32'hFF);
      s8_dv  = 1'b1;
      s8_ack = ack_junk ? 1'($urandom) : 1'b0;
      tick();
      s8_dv  = 1'b0;
      s8_ack = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] w;
    bit          exp_ovr8;
    bit          armed;
    int          k;
    int          n;

    rst = 1'b0;
    s1_start = 0; s1_dv = 0; s1_ack = 0; s1_din = '0;
    s8_start = 0; s8_dv = 0; s8_ack = 0; s8_din = '0;
    s32_start = 0; s32_dv = 0; s32_ack = 0; s32_din = '0;
    tick();
    tick();
    rst = 1'b1;

    chk("rst_q1", s1_q, 0);
    chk("rst_v1", s1_v, 0);
    chk("rst_busy1", s1_busy, 0);
    chk("rst_ovr8", s8_ovr, 0);

    start1();
    chk("w1_busy", s1_busy, 1);
    beats1(32'hA5A5_0F0F, 32, 0, 1'b1);
    chk("w1_valid", s1_v, 1);
    chk("w1_data", s1_q, 32'hA5A5_0F0F);
    chk("w1_busy_done", s1_busy, 0);
    s1_ack = 1'b1;
    tick();
    s1_ack = 1'b0;
    chk("w1_ack", s1_v, 0);

    start8();
    beats8(32'hDEAD_BEEF, 3, 1'b1);
    chk("w8_valid", s8_v, 1);
    chk("w8_data", s8_q, 32'hDEAD_BEEF);

    for (int i = 0; i < 2; i++) begin
      s8_din = 8'($urandom);
      s8_dv  = 1'b1;
      tick();
    end
    s8_dv = 1'b0;
    chk("ovr8_set", s8_ovr, 1);
    chk("ovr8_data", s8_q, 32'hDEAD_BEEF);
    chk("ovr8_valid", s8_v, 1);
    s8_ack = 1'b1;
    tick();
    s8_ack = 1'b0;
    chk("ovr8_ack", s8_v, 0);
    chk("ovr8_sticky", s8_ovr, 1);

    start1();
    beats1($urandom, 10, 1, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_busy", s1_busy, 0);
    chk("mid_rst_q", s1_q, 0);
    chk("mid_rst_ovr8", s8_ovr, 0);
    start1();
    beats1(32'h1234_5678, 32, 1, 1'b0);
    chk("after_rst_data", s1_q, 32'h1234_5678);
    chk("after_rst_valid", s1_v, 1);

    s1_ack   = 1'b1;
    s1_start = 1'b1;
    tick();
    s1_ack   = 1'b0;
    s1_start = 1'b0;
    chk("chain_busy", s1_busy, 1);
    chk("chain_valid", s1_v, 0);
    beats1(32'hFFFF_0000, 32, 0, 1'b0);
    chk("chain_data", s1_q, 32'hFFFF_0000);
    chk("chain_ovr", s1_ovr, 0);
    s1_ack = 1'b1;
    tick();
    s1_ack = 1'b0;

    s32_start = 1'b1;
    tick();
    s32_start = 1'b0;
    s32_din = 32'hCAFE_F00D;
    s32_dv  = 1'b1;
    tick();
    s32_dv  = 1'b0;
    chk("w32_valid", s32_v, 1);
    chk("w32_data", s32_q, 32'hCAFE_F00D);

    exp_ovr8 = 1'b0;
    armed    = 1'b0;
    for (int it = 0; it < 24; it++) begin
      w = $urandom;
      if (!armed) start8();
      beats8(w, 2, 1'b1);
      chk("rnd_data", s8_q, w);
      chk("rnd_valid", s8_v, 1);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        s8_din = 8'($urandom);
        s8_dv  = 1'b1;
        tick();
        s8_dv  = 1'b0;
      end
      if (k > 0) exp_ovr8 = 1'b1;
      chk("rnd_ovr", s8_ovr, 32'(exp_ovr8));
      chk("rnd_hold", s8_q, w);
      armed    = 1'($urandom);
      s8_ack   = 1'b1;
      s8_start = armed;
      tick();
      s8_ack   = 1'b0;
      s8_start = 1'b0;
      chk("rnd_ack", s8_v, 0);
      chk("rnd_busy", s8_busy, 32'(armed));
      if (!armed) repeat ($urandom_range(0, 3)) tick();
    end

`ifdef RX_TIMEOUT_EN
    start1();
    chk("to_clr", s1_to, 0);
    beats1($urandom, 5, 0, 1'b0);
    n = 0;
    while (s1_busy && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_flag", s1_to, 1);
    chk("to_valid", s1_v, 0);
    start1();
    chk("to_restart_clr", s1_to, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
